// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM state encoding,
// requester count, index width and the rotating-priority pick helper.
package rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First set request bit scanning upward from ptr, wrapping 7 -> 0.
  // Only meaningful when req != 0; the caller guarantees that.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3x8.sv
// 3-to-8 one-hot decoder used to expand the registered grant index.
module decoder3x8 (
  input  logic [2:0] in_idx,
  output logic [7:0] out_onehot
);

  assign out_onehot = 8'h01 << in_idx;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with hold-until-release grants.
// Optional grant timeout enabled by defining RR_ARBITER8_TIMEOUT_EN; without it
// the hold counter is not built and timeout is tied low.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  state_t           state_q,     state_d;
  logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [7:0]       dec_onehot;
  logic             release_w;

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q,  timeout_d;
`endif

  // Holder gives up the resource either explicitly or by dropping its request.
  assign release_w = done | ~req[gnt_idx_q];

  // Next-state: arbitrate in IDLE, hold/release (or time out) in BUSY.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
`ifdef RR_ARBITER8_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_idx_d   = rr_pick(req, ptr_q);
          gnt_valid_d = 1'b1;
          state_d     = BUSY;
`ifdef RR_ARBITER8_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      BUSY: begin
        // Normal release wins over a timeout landing on the same edge.
        if (release_w) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          state_d     = IDLE;
        end
`ifdef RR_ARBITER8_TIMEOUT_EN
        else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          state_d     = IDLE;
          timeout_d   = 1'b1;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  decoder3x8 u_dec (
    .in_idx     (gnt_idx_q),
    .out_onehot (dec_onehot)
  );

  assign gnt       = gnt_valid_q ? dec_onehot : 8'h00;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
`ifdef RR_ARBITER8_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
